// File: rtl/axil_pkg.sv
// axil_pkg: shared types and helpers
// for the AXI-Lite register bank.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  function automatic int unsigned addr_lsb(
    input int unsigned strb_w
  );
    return $clog2(strb_w);
  endfunction

  function automatic logic [31:0] addr_to_idx(
    input logic [63:0] addr,
    input int unsigned lsb
  );
    return 32'(addr >> lsb);
  endfunction

  function automatic logic num_regs_ok(
    input int unsigned n,
    input int unsigned aw,
    input int unsigned lsb
  );
    logic [63:0] span;
    if (aw <= lsb) return 1'b0;
    span = 64'd1 << (aw - lsb);
    return (n >= 32'd1) && (64'(n) <= span);
  endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// axil_hold_slot: one-entry holding register
// with a valid/ready push side.
module axil_hold_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] data
);

  logic push;

  assign push       = push_valid && !full;
  assign push_ready = !full;

  // occupancy: fill on handshake, drain on pop
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      full <= 1'b0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end
  end

  // payload is only loaded into an empty slot
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data <= '0;
    end else if (push) begin
      data <= push_data;
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// axil_regfile: parametrised AXI4-Lite slave
// register bank with RO slots and write pulses.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,

  input  logic [ADDR_WIDTH-1:0] axil_awaddr,
  input  logic [2:0]            axil_awprot,
  input  logic                  axil_awvalid,
  output logic                  axil_awready,

  input  logic [DATA_WIDTH-1:0] axil_wdata,
  input  logic [STRB_WIDTH-1:0] axil_wstrb,
  input  logic                  axil_wvalid,
  output logic                  axil_wready,

  output logic [1:0]            axil_bresp,
  output logic                  axil_bvalid,
  input  logic                  axil_bready,

  input  logic [ADDR_WIDTH-1:0] axil_araddr,
  input  logic [2:0]            axil_arprot,
  input  logic                  axil_arvalid,
  output logic                  axil_arready,

  output logic [DATA_WIDTH-1:0] axil_rdata,
  output logic [1:0]            axil_rresp,
  output logic                  axil_rvalid,
  input  logic                  axil_rready,

  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned ADDRLSB = addr_lsb(STRB_WIDTH);
  localparam int unsigned WPW     = STRB_WIDTH + DATA_WIDTH;

  if (!num_regs_ok(NUM_REGS, ADDR_WIDTH, ADDRLSB)) begin : g_bad_regs
    $error("axil_regfile: NUM_REGS exceeds address space");
  end

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("axil_regfile: DATA_WIDTH must be 32 or 64");
  end

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  w_full;
  logic [WPW-1:0]        w_payload;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  commit;

  logic [31:0]           aw_idx;
  logic [31:0]           ar_idx;
  logic [NUM_REGS-1:0]   aw_sel;
  logic [NUM_REGS-1:0]   ar_sel;
  logic                  aw_ok;
  logic                  ar_hit;
  logic                  ar_fire;
  logic [DATA_WIDTH-1:0] ar_val;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] view;

  logic                  bvalid_q;
  resp_t                 bresp_q;
  logic                  rvalid_q;
  resp_t                 rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  unused_ok;

  axil_hold_slot #(
    .W(ADDR_WIDTH)
  ) u_aw_slot (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_valid (axil_awvalid),
    .push_ready (axil_awready),
    .push_data  (axil_awaddr),
    .pop        (commit),
    .full       (aw_full),
    .data       (aw_addr)
  );

  axil_hold_slot #(
    .W(WPW)
  ) u_w_slot (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_valid (axil_wvalid),
    .push_ready (axil_wready),
    .push_data  ({axil_wstrb, axil_wdata}),
    .pop        (commit),
    .full       (w_full),
    .data       (w_payload)
  );

  assign w_strb = w_payload[WPW-1:DATA_WIDTH];
  assign w_data = w_payload[DATA_WIDTH-1:0];

  // a held pair commits once the B channel can take it
  assign commit = aw_full && w_full
               && (!bvalid_q || axil_bready);

  // one-hot decode of the held write and incoming read
  always_comb begin
    aw_idx = addr_to_idx(64'(aw_addr), ADDRLSB);
    ar_idx = addr_to_idx(64'(axil_araddr), ADDRLSB);
    aw_sel = '0;
    ar_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      aw_sel[i] = (aw_idx == 32'(i));
      ar_sel[i] = (ar_idx == 32'(i));
    end
    aw_ok  = |(aw_sel & ~RO_MASK);
    ar_hit = |ar_sel;
  end

  // read mux; no hit leaves the value at zero
  always_comb begin
    ar_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_sel[i]) begin
        ar_val = ar_val | view[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign view[g] = reg_i[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;

      // byte-strobed storage for a writable slot
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          q <= RESET_VAL;
        end else if (commit && aw_sel[g]) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb[b]) begin
              q[b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end
      end

      assign view[g] = q;
    end
  end

  assign reg_o = view;

  // B channel: load on commit, hold until bready
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (axil_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // single-cycle strobe for the register just written
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_pulse_q <= '0;
    end else if (commit && aw_ok) begin
      wr_pulse_q <= aw_sel;
    end else begin
      wr_pulse_q <= '0;
    end
  end

  assign axil_arready = !rvalid_q || axil_rready;
  assign ar_fire      = axil_arvalid && axil_arready;

  // R channel: capture on AR handshake, hold while stalled
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rresp_q  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= ar_val;
    end else if (axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign axil_bvalid = bvalid_q;
  assign axil_bresp  = bresp_q;
  assign axil_rvalid = rvalid_q;
  assign axil_rresp  = rresp_q;
  assign axil_rdata  = rdata_q;
  assign wr_pulse_o  = wr_pulse_q;

  assign unused_ok = ^{axil_awprot, axil_arprot, reg_i};

endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: randomized self-checking bench
// against a behavioural register-map model.
module tb_axil_regfile;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h8000;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [AW-1:0] axil_awaddr = '0;
  logic [2:0]    axil_awprot = '0;
  logic          axil_awvalid = 1'b0;
  logic          axil_awready;
  logic [DW-1:0] axil_wdata = '0;
  logic [SW-1:0] axil_wstrb = '0;
  logic          axil_wvalid = 1'b0;
  logic          axil_wready;
  logic [1:0]    axil_bresp;
  logic          axil_bvalid;
  logic          axil_bready = 1'b0;
  logic [AW-1:0] axil_araddr = '0;
  logic [2:0]    axil_arprot = '0;
  logic          axil_arvalid = 1'b0;
  logic          axil_arready;
  logic [DW-1:0] axil_rdata;
  logic [1:0]    axil_rresp;
  logic          axil_rvalid;
  logic          axil_rready = 1'b0;
  logic [NR*DW-1:0] reg_o;
  logic [NR*DW-1:0] reg_i = '0;
  logic [NR-1:0]    wr_pulse_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model [NR];

  always #5 clk = ~clk;

  axil_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (RO)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .axil_awaddr  (axil_awaddr),
    .axil_awprot  (axil_awprot),
    .axil_awvalid (axil_awvalid),
    .axil_awready (axil_awready),
    .axil_wdata   (axil_wdata),
    .axil_wstrb   (axil_wstrb),
    .axil_wvalid  (axil_wvalid),
    .axil_wready  (axil_wready),
    .axil_bresp   (axil_bresp),
    .axil_bvalid  (axil_bvalid),
    .axil_bready  (axil_bready),
    .axil_araddr  (axil_araddr),
    .axil_arprot  (axil_arprot),
    .axil_arvalid (axil_arvalid),
    .axil_arready (axil_arready),
    .axil_rdata   (axil_rdata),
    .axil_rresp   (axil_rresp),
    .axil_rvalid  (axil_rvalid),
    .axil_rready  (axil_rready),
    .reg_o        (reg_o),
    .reg_i        (reg_i),
    .wr_pulse_o   (wr_pulse_o)
  );

  // ---------------- reference model ----------------
  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a[AW-1:2]);
  endfunction

  function automatic bit writable(input logic [AW-1:0] a);
    int i;
    i = idx_of(a);
    if (i >= NR) return 1'b0;
    return !RO[i];
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [AW-1:0] a);
    return writable(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [NR-1:0] exp_pulse(input logic [AW-1:0] a);
    return writable(a) ? (NR'(1) << idx_of(a)) : '0;
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    int i;
    i = idx_of(a);
    if (i >= NR) return '0;
    if (RO[i]) return reg_i[i*DW +: DW];
    return model[i];
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [AW-1:0] a);
    return (idx_of(a) >= NR) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_write(input logic [AW-1:0] a,
                             input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
    int i;
    i = idx_of(a);
    if (!writable(a)) return;
    for (int b = 0; b < SW; b++)
      if (s[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // ---------------- bus drivers ----------------
  task automatic do_write(input  logic [AW-1:0] a,
                          input  logic [DW-1:0] d,
                          input  logic [SW-1:0] s,
                          output logic [1:0]    resp,
                          output logic [NR-1:0] pulse);
    bit aw_done, w_done, got, ah, wh;
    aw_done = 0; w_done = 0; got = 0;
    resp = 2'bxx; pulse = 'x;
    axil_awaddr = a; axil_wdata = d; axil_wstrb = s;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    axil_bready = 1'b1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      ah = axil_awvalid && axil_awready;
      wh = axil_wvalid && axil_wready;
      @(negedge clk);
      if (ah) begin axil_awvalid = 1'b0; aw_done = 1; end
      if (wh) begin axil_wvalid = 1'b0; w_done = 1; end
    end
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (axil_bvalid) begin
        got = 1; resp = axil_bresp; pulse = wr_pulse_o;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!(aw_done && w_done && got)) begin
      n_bad++;
      $display("FAIL wr_timeout a=%h got aw=%0d w=%0d b=%0d want 1 1 1",
               a, aw_done, w_done, got);
    end
  endtask

  task automatic do_read(input  logic [AW-1:0] a,
                         output logic [DW-1:0] d,
                         output logic [1:0]    resp);
    bit done, got, h;
    done = 0; got = 0;
    d = 'x; resp = 2'bxx;
    axil_araddr = a; axil_arvalid = 1'b1; axil_rready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      h = axil_arready;
      @(negedge clk);
      if (h) begin axil_arvalid = 1'b0; done = 1; end
    end
    axil_arvalid = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (axil_rvalid) begin
        got = 1; d = axil_rdata; resp = axil_rresp;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!(done && got)) begin
      n_bad++;
      $display("FAIL rd_timeout a=%h got ar=%0d r=%0d want 1 1", a, done, got);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit rv_ok;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (axil_bvalid !== 1'b0) begin n_bad++;
      $display("FAIL rst_bvalid got %b want 0", axil_bvalid); end
    n_cmp++; if (axil_rvalid !== 1'b0) begin n_bad++;
      $display("FAIL rst_rvalid got %b want 0", axil_rvalid); end
    n_cmp++; if ({axil_awready, axil_wready, axil_arready} !== 3'b111) begin n_bad++;
      $display("FAIL rst_ready got %b want 111",
               {axil_awready, axil_wready, axil_arready}); end
    n_cmp++; if (wr_pulse_o !== '0) begin n_bad++;
      $display("FAIL rst_pulse got %h want 0", wr_pulse_o); end
    n_cmp++; if ({axil_rdata, axil_rresp, axil_bresp} !== '0) begin n_bad++;
      $display("FAIL rst_rdata got %h/%b/%b want 0",
               axil_rdata, axil_rresp, axil_bresp); end
    rv_ok = 1;
    for (int i = 0; i < NR; i++)
      if (!RO[i] && reg_o[i*DW +: DW] !== model[i]) rv_ok = 0;
    n_cmp++; if (!rv_ok) begin n_bad++;
      $display("FAIL rst_regs got %h want all zero", reg_o); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    logic [1:0] r;
    axil_awaddr = 8'h04; axil_wdata = 32'hDEADBEEF; axil_wstrb = 4'hF;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1; axil_bready = 1'b1;
    n_cmp++; if ({axil_awready, axil_wready} !== 2'b11) begin n_bad++;
      $display("FAIL basic_ready got %b want 11", {axil_awready, axil_wready}); end
    @(negedge clk);
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    n_cmp++; if (axil_bvalid !== 1'b0) begin n_bad++;
      $display("FAIL basic_bvalid_t1 got %b want 0", axil_bvalid); end
    @(negedge clk);
    model_write(8'h04, 32'hDEADBEEF, 4'hF);
    n_cmp++; if ({axil_bvalid, axil_bresp} !== 3'b100) begin n_bad++;
      $display("FAIL basic_b_t2 got %b/%b want 1/00", axil_bvalid, axil_bresp); end
    n_cmp++; if (wr_pulse_o !== 16'h0002) begin n_bad++;
      $display("FAIL basic_pulse got %h want 0002", wr_pulse_o); end
    @(negedge clk);
    n_cmp++; if ({axil_bvalid, wr_pulse_o} !== '0) begin n_bad++;
      $display("FAIL basic_after got %b/%h want 0/0000", axil_bvalid, wr_pulse_o); end
    n_cmp++; if (reg_o[1*DW +: DW] !== model[1]) begin n_bad++;
      $display("FAIL basic_reg_o got %h want %h", reg_o[1*DW +: DW], model[1]); end
    do_read(8'h04, d, r);
    n_cmp++; if ({d, r} !== {exp_rdata(8'h04), 2'b00}) begin n_bad++;
      $display("FAIL basic_read got %h/%b want %h/00", d, r, exp_rdata(8'h04)); end
  endtask

  task automatic test_strobe();
    logic [DW-1:0] d;
    logic [1:0] r;
    logic [NR-1:0] p;
    do_write(8'h05, 32'h11223344, 4'b0101, r, p);
    model_write(8'h05, 32'h11223344, 4'b0101);
    n_cmp++; if ({r, p} !== {2'b00, 16'h0002}) begin n_bad++;
      $display("FAIL strb_b got %b/%h want 00/0002", r, p); end
    do_read(8'h06, d, r);
    n_cmp++; if ({d, r} !== {model[1], 2'b00}) begin n_bad++;
      $display("FAIL strb_read got %h/%b want %h/00", d, r, model[1]); end
  endtask

  task automatic test_w_first_bp();
    logic [DW-1:0] d1, d2;
    bit got;
    d1 = $urandom; d2 = $urandom;
    axil_bready = 1'b0;
    axil_wdata = d1; axil_wstrb = 4'hF; axil_wvalid = 1'b1;
    @(negedge clk);
    axil_wvalid = 1'b0;
    n_cmp++; if ({axil_wready, axil_awready, axil_bvalid} !== 3'b010) begin n_bad++;
      $display("FAIL wf_held got w=%b aw=%b b=%b want 0 1 0",
               axil_wready, axil_awready, axil_bvalid); end
    repeat (2) @(negedge clk);
    axil_awaddr = 8'h08; axil_awvalid = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (axil_bvalid) got = 1;
      else @(negedge clk);
    end
    model_write(8'h08, d1, 4'hF);
    n_cmp++; if ({got, axil_bresp, wr_pulse_o} !== {1'b1, 2'b00, 16'h0004}) begin
      n_bad++;
      $display("FAIL wf_b1 got %b/%b/%h want 1/00/0004", got, axil_bresp, wr_pulse_o);
    end
    axil_awaddr = 8'h0C; axil_wdata = d2; axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      axil_awvalid = 1'b0; axil_wvalid = 1'b0;
      n_cmp++;
      if ({axil_bvalid, axil_bresp, wr_pulse_o, axil_awready, axil_wready}
          !== {1'b1, 2'b00, 16'h0000, 2'b00}
          || reg_o[3*DW +: DW] !== model[3]) begin
        n_bad++;
        $display("FAIL wf_stall%0d got b=%b r=%b p=%h rdy=%b%b reg3=%h want 1 00 0000 00 %h",
                 k, axil_bvalid, axil_bresp, wr_pulse_o, axil_awready,
                 axil_wready, reg_o[3*DW +: DW], model[3]);
      end
    end
    axil_bready = 1'b1;
    @(negedge clk);
    model_write(8'h0C, d2, 4'hF);
    n_cmp++; if ({axil_bvalid, wr_pulse_o} !== {1'b1, 16'h0008}) begin n_bad++;
      $display("FAIL wf_b2 got %b/%h want 1/0008", axil_bvalid, wr_pulse_o); end
    n_cmp++;
    if (reg_o[2*DW +: DW] !== model[2] || reg_o[3*DW +: DW] !== model[3]) begin
      n_bad++;
      $display("FAIL wf_data got %h %h want %h %h", reg_o[2*DW +: DW],
               reg_o[3*DW +: DW], model[2], model[3]);
    end
    @(negedge clk);
    n_cmp++; if ({axil_bvalid, axil_awready, axil_wready} !== 3'b011) begin n_bad++;
      $display("FAIL wf_idle got %b want 011",
               {axil_bvalid, axil_awready, axil_wready}); end
  endtask

  task automatic test_errors();
    logic [DW-1:0] d;
    logic [1:0] r;
    logic [NR-1:0] p;
    bit ok;
    reg_i[15*DW +: DW] = 32'hCAFE0001;
    do_write(8'h3C, $urandom, 4'hF, r, p);
    n_cmp++; if ({r, p} !== {exp_wresp(8'h3C), exp_pulse(8'h3C)}) begin n_bad++;
      $display("FAIL ro_b got %b/%h want %b/%h", r, p,
               exp_wresp(8'h3C), exp_pulse(8'h3C)); end
    do_read(8'h3C, d, r);
    n_cmp++; if ({d, r} !== {exp_rdata(8'h3C), 2'b00}) begin n_bad++;
      $display("FAIL ro_read got %h/%b want %h/00", d, r, exp_rdata(8'h3C)); end
    n_cmp++; if (reg_o[15*DW +: DW] !== 32'hCAFE0001) begin n_bad++;
      $display("FAIL ro_reg_o got %h want cafe0001", reg_o[15*DW +: DW]); end
    do_write(8'h40, $urandom, 4'hF, r, p);
    n_cmp++; if ({r, p} !== {2'b10, 16'h0000}) begin n_bad++;
      $display("FAIL oor_b got %b/%h want 10/0000", r, p); end
    do_read(8'h40, d, r);
    n_cmp++; if ({d, r} !== {exp_rdata(8'h40), exp_rresp(8'h40)}) begin n_bad++;
      $display("FAIL oor_read got %h/%b want 0/10", d, r); end
    ok = 1;
    for (int i = 0; i < NR; i++)
      if (!RO[i] && reg_o[i*DW +: DW] !== model[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++;
      $display("FAIL err_nochange got %h", reg_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    logic [NR-1:0] p;
    logic [DW-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      do_write(AW'(i * 4), v, 4'hF, r, p);
      model_write(AW'(i * 4), v, 4'hF);
    end
    axil_rready = 1'b1;
    axil_araddr = 8'h00; axil_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({axil_rvalid, axil_rdata, axil_rresp} !== {1'b1, model[i], 2'b00}) begin
        n_bad++;
        $display("FAIL b2b_%0d got %b/%h/%b want 1/%h/00", i, axil_rvalid,
                 axil_rdata, axil_rresp, model[i]);
      end
      if (i < 3) axil_araddr = AW'((i + 1) * 4);
      else axil_arvalid = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (axil_rvalid !== 1'b0) begin n_bad++;
      $display("FAIL b2b_end got %b want 0", axil_rvalid); end
    axil_araddr = 8'h08; axil_arvalid = 1'b1;
    @(negedge clk);
    axil_rready = 1'b0;
    axil_araddr = 8'h0C;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({axil_rvalid, axil_rdata, axil_arready} !== {1'b1, model[2], 1'b0}) begin
        n_bad++;
        $display("FAIL stall_%0d got %b/%h/%b want 1/%h/0", k, axil_rvalid,
                 axil_rdata, axil_arready, model[2]);
      end
    end
    axil_rready = 1'b1;
    @(negedge clk);
    axil_arvalid = 1'b0;
    n_cmp++; if ({axil_rvalid, axil_rdata} !== {1'b1, model[3]}) begin n_bad++;
      $display("FAIL stall_next got %b/%h want 1/%h", axil_rvalid, axil_rdata, model[3]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [1:0] r;
    logic [NR-1:0] p;
    for (int n = 0; n < 60; n++) begin
      a = AW'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) reg_i[15*DW +: DW] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = SW'($urandom);
        do_write(a, d, s, r, p);
        n_cmp++; if ({r, p} !== {exp_wresp(a), exp_pulse(a)}) begin n_bad++;
          $display("FAIL rnd_w a=%h got %b/%h want %b/%h", a, r, p,
                   exp_wresp(a), exp_pulse(a)); end
        model_write(a, d, s);
      end else begin
        do_read(a, d, r);
        n_cmp++; if ({d, r} !== {exp_rdata(a), exp_rresp(a)}) begin n_bad++;
          $display("FAIL rnd_r a=%h got %h/%b want %h/%b", a, d, r,
                   exp_rdata(a), exp_rresp(a)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    axil_bready = 1'b0;
    axil_awaddr = 8'h14; axil_wdata = 32'h5A5A_0F0F | $urandom; axil_wstrb = 4'hF;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (axil_bvalid) got = 1;
      else @(negedge clk);
    end
    axil_wdata = $urandom; axil_wvalid = 1'b1;
    @(negedge clk);
    axil_wvalid = 1'b0;
    n_cmp++; if ({got, axil_bvalid, axil_wready} !== 3'b110) begin n_bad++;
      $display("FAIL mid_pre got %b%b%b want 110", got, axil_bvalid, axil_wready); end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    n_cmp++; if ({axil_bvalid, axil_wready, axil_awready} !== 3'b011) begin n_bad++;
      $display("FAIL mid_rst got %b want 011",
               {axil_bvalid, axil_wready, axil_awready}); end
    ok = 1;
    for (int i = 0; i < NR; i++)
      if (!RO[i] && reg_o[i*DW +: DW] !== model[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++;
      $display("FAIL mid_regs got %h want zeros", reg_o); end
    @(negedge clk);
    rstn = 1'b1;
    axil_bready = 1'b1;
    axil_awaddr = 8'h14; axil_awvalid = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({axil_bvalid, wr_pulse_o, axil_awready} !== '0
        || reg_o[5*DW +: DW] !== model[5]) begin
      n_bad++;
      $display("FAIL mid_nocommit got b=%b p=%h aw=%b reg5=%h want 0 0 0 %h",
               axil_bvalid, wr_pulse_o, axil_awready, reg_o[5*DW +: DW], model[5]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_w_first_bp();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
Parametrised AXI4-Lite slave register bank, the successor to the fixed 4-register example slave. It provides:
- NUM_REGS registers with byte-strobe writes.
- Independent AW/W acceptance.
- Per-register read-only mapping to hardware inputs.
- SLVERR for out-of-range or read-only writes.
- Per-register write pulses.

It sits between an AXI-Lite interconnect port and core control/status logic.

Parameters:
- ADDR_WIDTH, 8, byte address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- STRB_WIDTH, DATA_WIDTH/8, strobe width.
- NUM_REGS, 16, register count; must satisfy 1 ≤ NUM_REGS ≤ 2**(ADDR_WIDTH-ADDRLSB).
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only (value sourced from reg_i).
- RESET_VAL, 0, reset value of every writable register.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- axil_awaddr  in  ADDR_WIDTH; axil_awprot  in  3 (ignored); axil_awvalid  in  1; axil_awready  out  1.
- axil_wdata  in  DATA_WIDTH; axil_wstrb  in  STRB_WIDTH; axil_wvalid  in  1; axil_wready  out  1.
- axil_bresp  out  2; axil_bvalid  out  1; axil_bready  in  1.
- axil_araddr  in  ADDR_WIDTH; axil_arprot  in  3 (ignored); axil_arvalid  in  1; axil_arready  out  1.
- axil_rdata  out  DATA_WIDTH; axil_rresp  out  2; axil_rvalid  out  1; axil_rready  in  1.
- reg_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; RO slots carry reg_i.
- reg_i  in  NUM_REGS*DATA_WIDTH  hardware values for RO registers; non-RO slots unused.
- wr_pulse_o  out  NUM_REGS  one-cycle strobe per register on a successful write.

Behaviour:
- Reset is asynchronous on rstn_i low:
  - bvalid, rvalid, wr_pulse_o, bresp, rresp and rdata all go to 0.
  - Writable registers go to RESET_VAL; AW/W holding slots are cleared.
  - awready, wready and arready read 1 after reset.
- Reset mid-transaction abandons all in-flight transactions; no write commits.
- Addressing: ADDRLSB = $clog2(STRB_WIDTH). Index = addr[ADDR_WIDTH-1:ADDRLSB]; low byte-address bits are ignored.
- Write channel:
  - AW and W are each captured into their own one-entry holding slot.
  - axil_awready = !aw_full; axil_wready = !w_full. Either may arrive first or both in the same cycle.
- Write commit:
  - Occurs on the edge ending cycle C, where C is any cycle with aw_full && w_full && (!bvalid || bready).
  - Only bytes whose wstrb bit is set update; other bytes are unchanged.
  - Both slots clear; bvalid=1 from C+1; wr_pulse_o[idx]=1 for cycle C+1 only.
- Write response:
  - OKAY (2'b00) for a writable, in-range index.
  - SLVERR (2'b10) for index ≥ NUM_REGS or RO_MASK[idx]=1. No register change and no wr_pulse in that case.
  - wstrb=0 to a valid index gives OKAY and a wr_pulse, with no data change.
- Write latency: AW and W handshaken together in cycle T leads to bvalid in cycle T+2. Sustained throughput is one write per 2 cycles.
- bvalid holds, with bresp stable, until bready is seen; a pending bvalid without bready blocks the next commit.
- Read channel:
  - axil_arready = !rvalid || rready.
  - An AR handshake in cycle T registers rdata/rresp and sets rvalid in T+1.
  - With rready held high, reads complete back-to-back at one per cycle.
  - rdata/rresp stay stable while rvalid && !rready.
- Read data:
  - In range: rdata = register value (reg_i for RO), OKAY.
  - Out of range: rdata = 0, SLVERR.
- Same-cycle read and write to the same register: the read returns the pre-commit value.
- reg_o is registered for writable slots and a combinational pass-through of reg_i for RO slots.

Decomposition:
- Package axil_pkg:
  - resp_t encoding: OKAY=2'b00, SLVERR=2'b10.
  - addr_to_idx function, plus ADDRLSB computation.
  - Elaboration-time check of NUM_REGS against address space.
- Sub-module axil_hold_slot: a one-entry valid/ready holding register, parametrised on payload width. It is instantiated twice: AW payload = addr; W payload = {strb, data}.

Test Plan:
(Bench config: NUM_REGS=16, DATA_WIDTH=32, RO_MASK=16'h8000.)
- Reset release, then write 0xDEADBEEF to addr 0x04 with strb 4'hF, then read 0x04 → bresp OKAY with bvalid 2 cycles after the handshake; wr_pulse_o=16'h0002 for one cycle; rdata 0xDEADBEEF, OKAY.
- Partial strobe: reg1=0xDEADBEEF, write 0x11223344 with strb 4'b0101 → reg1 reads 0xDE22BE44.
- W presented 3 cycles before AW; bready held low for 4 cycles after bvalid → wready drops after W is captured; the second write's commit stalls until bready; no data loss.
- Write to 0x3C (RO reg 15) with reg_i[15]=0xCAFE0001 → bresp SLVERR, no wr_pulse; reading 0x3C gives 0xCAFE0001 OKAY. Write to 0x40 (ADDR_WIDTH=8) → SLVERR; read of 0x40 → rdata 0, SLVERR.
- Four back-to-back reads of 0x00, 0x04, 0x08, 0x0C with rready=1 → four consecutive rvalid cycles with correct data. rready low for 2 cycles → rdata stable and arready low.
- Assert rstn_i low while bvalid=1 and a W is held → bvalid=0 immediately; registers equal RESET_VAL; the held write is never committed.
